gpr_wport_arb: RTL and testbench

- Arbiter and sequencer for the single GPR write port of the register file.
- Two writers share the port:
  - port 0: the in-order write-back stage.
  - port 1: the long-latency unit (mul/div result return).
- WB normally wins. A wait counter bounds starvation of the long-latency unit by forcing one grant to it after MAX_WAIT blocked cycles.
- The winning write is registered and driven to the RF write port one cycle after acceptance.

---
 rtl/gpr_wport_arb_if.sv | 32 +++
 rtl/gpr_wport_arb.sv | 106 ++++++++++
 tb/tb_gpr_wport_arb.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gpr_wport_arb_if.sv
// Request and RF-write signal bundle for the GPR write-port arbiter.
// The slave modport is the arbiter side and the master modport is the requester/RF side.
interface gpr_wport_arb_if #(
  parameter int unsigned GPR_ADDR_WD = 5,
  parameter int unsigned GPR_WD      = 64
);
  logic                   i_wb_valid;
  logic                   o_wb_ready;
  logic                   i_wb_wen;
  logic [GPR_ADDR_WD-1:0] i_wb_rd;
  logic [GPR_WD-1:0]      i_wb_wdata;
  logic                   i_lu_valid;
  logic                   o_lu_ready;
  logic [GPR_ADDR_WD-1:0] i_lu_rd;
  logic [GPR_WD-1:0]      i_lu_wdata;
  logic                   o_rf_wen;
  logic [GPR_ADDR_WD-1:0] o_rf_waddr;
  logic [GPR_WD-1:0]      o_rf_wdata;
  logic                   o_force;

  modport slave (
    input  i_wb_valid, i_wb_wen, i_wb_rd, i_wb_wdata,
    input  i_lu_valid, i_lu_rd, i_lu_wdata,
    output o_wb_ready, o_lu_ready, o_rf_wen, o_rf_waddr, o_rf_wdata, o_force
  );

  modport master (
    output i_wb_valid, i_wb_wen, i_wb_rd, i_wb_wdata,
    output i_lu_valid, i_lu_rd, i_lu_wdata,
    input  o_wb_ready, o_lu_ready, o_rf_wen, o_rf_waddr, o_rf_wdata, o_force
  );
endinterface

// File: rtl/gpr_wport_arb.sv
// GPR write-port arbiter: WB wins by default, and the long-latency unit gets a forced grant after MAX_WAIT blocked cycles.
// Optional statistics counters are enabled by defining GPR_WPORT_ARB_STAT_EN.
module gpr_wport_arb #(
  parameter int unsigned GPR_ADDR_WD = 5,
  parameter int unsigned GPR_WD      = 64,
  parameter int unsigned MAX_WAIT    = 4,
  parameter int unsigned WAIT_CNT_WD = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  gpr_wport_arb_if.slave     bus
`ifdef GPR_WPORT_ARB_STAT_EN
  ,
  output logic [31:0]        o_stat_conflict,
  output logic [31:0]        o_stat_force
`endif
);

  typedef enum logic {S_NORM, S_FORCE} state_t;

  localparam logic [WAIT_CNT_WD-1:0] LAST_WAIT = WAIT_CNT_WD'(MAX_WAIT - 1);

  state_t                 state, next_state;
  logic [WAIT_CNT_WD-1:0] wait_cnt, next_cnt;
  logic                   wb_ready, lu_ready;
  logic                   wb_xfer, lu_xfer;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_NORM;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = wait_cnt;
    wb_ready   = 1'b1;
    lu_ready   = 1'b0;
    unique case (state)
      S_NORM: begin
        lu_ready = !bus.i_wb_valid;
        if (!bus.i_lu_valid || !bus.i_wb_valid) begin
          next_cnt = '0;
        end else begin
          if (wait_cnt == LAST_WAIT) next_state = S_FORCE;
          if (wait_cnt != '1) next_cnt = wait_cnt + 1'b1;
        end
      end
      S_FORCE: begin
        // Leave after one cycle, whether the LU transfers or has dropped valid.
        wb_ready   = 1'b0;
        lu_ready   = 1'b1;
        next_state = S_NORM;
        next_cnt   = '0;
      end
      default: begin
        next_state = S_NORM;
        next_cnt   = '0;
      end
    endcase
  end

  assign wb_xfer        = bus.i_wb_valid && wb_ready;
  assign lu_xfer        = bus.i_lu_valid && lu_ready;
  assign bus.o_wb_ready = wb_ready;
  assign bus.o_lu_ready = lu_ready;
  assign bus.o_force    = (state == S_FORCE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_rf_wen   <= 1'b0;
      bus.o_rf_waddr <= '0;
      bus.o_rf_wdata <= '0;
    end else if (wb_xfer) begin
      bus.o_rf_wen   <= bus.i_wb_wen && (bus.i_wb_rd != GPR_ADDR_WD'(0));
      bus.o_rf_waddr <= bus.i_wb_rd;
      bus.o_rf_wdata <= bus.i_wb_wdata;
    end else if (lu_xfer) begin
      bus.o_rf_wen   <= (bus.i_lu_rd != GPR_ADDR_WD'(0));
      bus.o_rf_waddr <= bus.i_lu_rd;
      bus.o_rf_wdata <= bus.i_lu_wdata;
    end else begin
      bus.o_rf_wen   <= 1'b0;
    end
  end

`ifdef GPR_WPORT_ARB_STAT_EN
  // Only arbitration conflicts in S_NORM are counted; the forced-grant cycle is excluded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stat_conflict <= '0;
      o_stat_force    <= '0;
    end else begin
      if (state == S_NORM && bus.i_wb_valid && bus.i_lu_valid)
        o_stat_conflict <= o_stat_conflict + 32'd1;
      if (state == S_NORM && next_state == S_FORCE)
        o_stat_force <= o_stat_force + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gpr_wport_arb.sv
// Directed self-checking bench for gpr_wport_arb (MAX_WAIT=4).
// Stat-counter checks are included when GPR_WPORT_ARB_STAT_EN is defined.
module tb_gpr_wport_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  gpr_wport_arb_if #(.GPR_ADDR_WD(5), .GPR_WD(64)) bus ();

`ifdef GPR_WPORT_ARB_STAT_EN
  logic [31:0] stat_conflict, stat_force;
`endif

  gpr_wport_arb #(
    .GPR_ADDR_WD(5), .GPR_WD(64), .MAX_WAIT(4), .WAIT_CNT_WD(8)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus.slave)
`ifdef GPR_WPORT_ARB_STAT_EN
    ,
    .o_stat_conflict(stat_conflict),
    .o_stat_force(stat_force)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wbv, input logic wen, input logic [4:0] wrd, input logic [63:0] wdat,
                       input logic luv, input logic [4:0] lrd, input logic [63:0] ldat);
    bus.i_wb_valid = wbv;
    bus.i_wb_wen   = wen;
    bus.i_wb_rd    = wrd;
    bus.i_wb_wdata = wdat;
    bus.i_lu_valid = luv;
    bus.i_lu_rd    = lrd;
    bus.i_lu_wdata = ldat;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_wen", bus.o_rf_wen, 0);
    check("rst_waddr", bus.o_rf_waddr, 0);
    check("rst_wdata", bus.o_rf_wdata, 0);
    check("rst_force", bus.o_force, 0);
    check("rst_wb_ready", bus.o_wb_ready, 1);
    check("rst_lu_ready", bus.o_lu_ready, 1);
    #9 rst_n = 1'b1;
    tick();

    // WB-only write, then asynchronous reset while o_rf_wen is high
    drive(1, 1, 5, 64'hDEAD, 0, 0, 0);
    check("wb_only_ready", bus.o_wb_ready, 1);
    check("wb_only_lu_ready", bus.o_lu_ready, 0);
    tick();
    check("wb_only_wen", bus.o_rf_wen, 1);
    check("wb_only_waddr", bus.o_rf_waddr, 5);
    check("wb_only_wdata", bus.o_rf_wdata, 64'hDEAD);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_wen", bus.o_rf_wen, 0);
    check("async_rst_waddr", bus.o_rf_waddr, 0);
    check("async_rst_wdata", bus.o_rf_wdata, 0);
    check("async_rst_force", bus.o_force, 0);
    rst_n = 1'b1;
    tick();

    // LU-only write to x0 completes the handshake without a write
    drive(0, 0, 0, 0, 1, 0, 64'h1234);
    check("lu_only_ready", bus.o_lu_ready, 1);
    tick();
    check("lu_x0_wen", bus.o_rf_wen, 0);
    check("lu_x0_wdata", bus.o_rf_wdata, 64'h1234);
    check("lu_x0_force", bus.o_force, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("idle_wen", bus.o_rf_wen, 0);

    // WB with wen=0 and WB to x0
    drive(1, 0, 3, 64'h55, 0, 0, 0);
    tick();
    check("wb_nowen_wen", bus.o_rf_wen, 0);
    check("wb_nowen_waddr", bus.o_rf_waddr, 3);
    drive(1, 1, 0, 64'h66, 0, 0, 0);
    tick();
    check("wb_x0_wen", bus.o_rf_wen, 0);
    check("wb_x0_wdata", bus.o_rf_wdata, 64'h66);

    // Continuous conflict: four WB grants, then a forced LU grant
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 5'(10 + i), 64'(i), 1, 7, 64'h77);
      check("conf_wb_ready", bus.o_wb_ready, 1);
      check("conf_lu_ready", bus.o_lu_ready, 0);
      check("conf_force", bus.o_force, 0);
      tick();
      check("conf_waddr", bus.o_rf_waddr, 64'(10 + i));
      check("conf_wdata", bus.o_rf_wdata, 64'(i));
    end
    drive(1, 1, 20, 64'h20, 1, 7, 64'h77);
    check("force_on", bus.o_force, 1);
    check("force_wb_ready", bus.o_wb_ready, 0);
    check("force_lu_ready", bus.o_lu_ready, 1);
    tick();
    check("forced_wen", bus.o_rf_wen, 1);
    check("forced_waddr", bus.o_rf_waddr, 7);
    check("forced_wdata", bus.o_rf_wdata, 64'h77);
    check("force_off", bus.o_force, 0);
    drive(1, 1, 20, 64'h20, 0, 0, 0);
    check("post_force_wb_ready", bus.o_wb_ready, 1);
    tick();
    check("post_force_waddr", bus.o_rf_waddr, 20);

    // LU blocked two cycles, then accepted when WB idles; the count restarts afterwards
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 5'(1 + i), 64'(i), 1, 9, 64'h99);
      check("blk2_lu_ready", bus.o_lu_ready, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 9, 64'h99);
    check("blk2_gap_lu_ready", bus.o_lu_ready, 1);
    tick();
    check("blk2_lu_waddr", bus.o_rf_waddr, 9);
    check("blk2_lu_wen", bus.o_rf_wen, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'(1 + i), 64'(i), 1, 8, 64'h88);
      tick();
      check("restart_no_force", bus.o_force, 0);
    end
    drive(1, 1, 4, 64'h4, 1, 8, 64'h88);
    tick();
    check("restart_force", bus.o_force, 1);

    // LU drops valid while forced: no write, back to normal
    drive(1, 1, 6, 64'h6, 0, 0, 0);
    check("drop_lu_ready", bus.o_lu_ready, 1);
    check("drop_wb_ready", bus.o_wb_ready, 0);
    tick();
    check("drop_wen", bus.o_rf_wen, 0);
    check("drop_force", bus.o_force, 0);
    check("drop_wb_ready_after", bus.o_wb_ready, 1);

`ifdef GPR_WPORT_ARB_STAT_EN
    check("stat_force", 64'(stat_force), 2);
    check("stat_conflict", 64'(stat_conflict), 10);
`endif

    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
